// File: rtl/traffic_scheduler.sv
// Four-way intersection phase scheduler: round-robin green grant among waiting lanes,
// each green followed by yellow and an all-red clearance, with a per-phase countdown.
module traffic_scheduler #(
    parameter int GREEN_TIME  = 20,
    parameter int YELLOW_TIME = 3,
    parameter int CLEAR_TIME  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       l1,
    input  logic       l2,
    input  logic       l3,
    input  logic       l4,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [4:0] countDown
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;
    localparam logic [1:0] ST_CLEAR  = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

    // First requesting lane strictly after last_idx, wrapping; last_idx itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last_idx);
        logic       found;
        logic [1:0] idx;
        rr_pick = last_idx;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_idx + 2'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    logic [1:0] state_r;
    logic [1:0] cur_r;
    logic [1:0] last_r;
    logic [4:0] cnt_r;
    logic [3:0] green_r;
    logic [3:0] yellow_r;

    logic [3:0] req_s;
    logic       any_req_s;
    logic [1:0] pick_s;
    logic       rest_s;

    assign req_s     = {l4, l3, l2, l1};
    assign any_req_s = |req_s;
    assign pick_s    = rr_pick(req_s, last_r);
    // Only the current lane wants the road: keep it green instead of cycling through yellow.
    assign rest_s    = ~|(req_s & ~onehot4(cur_r)) && req_s[cur_r];

    assign green     = green_r;
    assign yellow    = yellow_r;
    assign countDown = cnt_r;

    // Phase sequencer: state, lane indices, countdown and lamp registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cur_r    <= 2'd0;
            last_r   <= 2'd3;
            cnt_r    <= 5'd0;
            green_r  <= 4'b0000;
            yellow_r <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        state_r <= ST_GREEN;
                        cur_r   <= pick_s;
                        last_r  <= pick_s;
                        green_r <= onehot4(pick_s);
                        cnt_r   <= 5'(GREEN_TIME);
                    end else begin
                        cnt_r    <= 5'd0;
                        green_r  <= 4'b0000;
                        yellow_r <= 4'b0000;
                    end
                end
                ST_GREEN: begin
                    if (cnt_r > 5'd1) begin
                        cnt_r <= cnt_r - 5'd1;
                    end else if (rest_s) begin
                        cnt_r <= 5'(GREEN_TIME);
                    end else begin
                        state_r  <= ST_YELLOW;
                        green_r  <= 4'b0000;
                        yellow_r <= onehot4(cur_r);
                        cnt_r    <= 5'(YELLOW_TIME);
                    end
                end
                ST_YELLOW: begin
                    if (cnt_r > 5'd1) begin
                        cnt_r <= cnt_r - 5'd1;
                    end else begin
                        state_r  <= ST_CLEAR;
                        yellow_r <= 4'b0000;
                        cnt_r    <= 5'(CLEAR_TIME);
                    end
                end
                ST_CLEAR: begin
                    if (cnt_r > 5'd1) begin
                        cnt_r <= cnt_r - 5'd1;
                    end else if (any_req_s) begin
                        state_r <= ST_GREEN;
                        cur_r   <= pick_s;
                        last_r  <= pick_s;
                        green_r <= onehot4(pick_s);
                        cnt_r   <= 5'(GREEN_TIME);
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 5'd0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= 5'd0;
                    green_r  <= 4'b0000;
                    yellow_r <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_scheduler.sv
// Directed bench for traffic_scheduler with default timing (20/3/1); outputs sampled on falling clk.
module tb_traffic_scheduler;

    localparam int GT = 20;
    localparam int YT = 3;
    localparam int CT = 1;

    logic       clk;
    logic       rst_n;
    logic       l1, l2, l3, l4;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [4:0] countDown;

    int vec_cnt;
    int err_cnt;

    traffic_scheduler #(.GREEN_TIME(GT), .YELLOW_TIME(YT), .CLEAR_TIME(CT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .l1        (l1),
        .l2        (l2),
        .l3        (l3),
        .l4        (l4),
        .green     (green),
        .yellow    (yellow),
        .countDown (countDown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [3:0] ey, input int ecd);
        logic [3:0] lamps;
        lamps = green | yellow;
        chk({tag, ".green"}, 32'(green), 32'(eg));
        chk({tag, ".yellow"}, 32'(yellow), 32'(ey));
        chk({tag, ".countDown"}, 32'(countDown), 32'(ecd));
        chk({tag, ".onehot"}, 32'($onehot0(lamps)), 32'd1);
        chk({tag, ".excl"}, 32'(green & yellow), 32'd0);
    endtask

    // Checks one full grant of lane (0..3) starting at the current sample point.
    task automatic check_grant(input string tag, input int lane);
        logic [3:0] oh;
        oh = 4'b0001 << lane;
        for (int i = 0; i < GT; i++) begin
            chk_out({tag, ".g"}, oh, 4'b0000, GT - i);
            step();
        end
        for (int i = 0; i < YT; i++) begin
            chk_out({tag, ".y"}, 4'b0000, oh, YT - i);
            step();
        end
        for (int i = 0; i < CT; i++) begin
            chk_out({tag, ".c"}, 4'b0000, 4'b0000, CT - i);
            step();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {l4, l3, l2, l1} = 4'b0000;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n   = 1'b0;
        {l4, l3, l2, l1} = 4'b0000;

        // Reset and 50 idle cycles
        do_reset();
        for (int i = 0; i < 50; i++) begin
            chk_out("idle", 4'b0000, 4'b0000, 0);
            step();
        end

        // Lane 3 alone rests in green for three periods
        l3 = 1'b1;
        step();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < GT; i++) begin
                chk_out("rest3", 4'b0100, 4'b0000, GT - i);
                step();
            end
        end
        chk_out("rest3.reload", 4'b0100, 4'b0000, GT);

        // Lanes 1 and 3 alternate with period 24
        do_reset();
        chk_out("rst2", 4'b0000, 4'b0000, 0);
        l1 = 1'b1;
        l3 = 1'b1;
        step();
        check_grant("alt.l1a", 0);
        check_grant("alt.l3", 2);
        check_grant("alt.l1b", 0);
        chk_out("alt.l3b", 4'b0100, 4'b0000, GT);

        // All four lanes rotate 1,2,3,4,1
        do_reset();
        {l4, l3, l2, l1} = 4'b1111;
        step();
        check_grant("all.l1", 0);
        check_grant("all.l2", 1);
        check_grant("all.l3", 2);
        check_grant("all.l4", 3);
        chk_out("all.l1b", 4'b0001, 4'b0000, GT);

        // Single-cycle l2 pulse gives one full grant then IDLE
        do_reset();
        step();
        chk_out("pulse.idle", 4'b0000, 4'b0000, 0);
        l2 = 1'b1;
        step();
        l2 = 1'b0;
        check_grant("pulse", 1);
        chk_out("pulse.back", 4'b0000, 4'b0000, 0);
        step();
        chk_out("pulse.stay", 4'b0000, 4'b0000, 0);

        // Reset mid-yellow of lane 2; lane 1 granted first afterwards
        do_reset();
        l1 = 1'b1;
        l2 = 1'b1;
        step();
        check_grant("mid.l1", 0);
        for (int i = 0; i < GT; i++) begin
            chk_out("mid.l2g", 4'b0010, 4'b0000, GT - i);
            step();
        end
        chk_out("mid.l2y", 4'b0000, 4'b0010, YT);
        rst_n = 1'b0;
        step();
        chk_out("mid.rst", 4'b0000, 4'b0000, 0);
        rst_n = 1'b1;
        step();
        chk_out("mid.regrant", 4'b0001, 4'b0000, GT);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
